// File: rtl/zports_pkg.sv
// Shared constants for the zports register file: register indices and field positions.
package zports_pkg;

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] REG_SLADDR = 2'd0;
    localparam logic [1:0] REG_CFG    = 2'd1;
    localparam logic [1:0] REG_RST    = 2'd2;
    localparam logic [1:0] REG_INT    = 2'd3;

    localparam int unsigned CFG_WIN_LSB  = 0;
    localparam int unsigned CFG_ENA_BIT  = 2;
    localparam int unsigned CFG_W5P_BIT  = 3;
    localparam int unsigned CFG_W        = 4;

    localparam int unsigned RST_W5_BIT   = 0;
    localparam int unsigned RST_SL_BIT   = 1;

    localparam int unsigned INT_SL_BIT   = 0;
    localparam int unsigned INT_W5_BIT   = 1;
    localparam int unsigned INT_MASK_LSB = 4;

    localparam logic [DATA_W-1:0] SLADDR_RD_VAL = 8'hFF;

endpackage

// File: rtl/zports_zsync.sv
// Two-flop synchroniser with async active-low reset; RST_VAL sets the reset level.
module zsync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/zports.sv
// ZX port control/status register file: write capture, CFG, chip reset timers and interrupts.
// Interrupt logic and register 3 are present only when ZPORTS_INT_EN is defined.
module zports
    import zports_pkg::*;
#(
    parameter int unsigned RST_LEN = 32
) (
    input  logic              fclk,
    input  logic              rst_n,
    input  logic              ports_wrena,
    input  logic              ports_wrstb_n,
    input  logic [1:0]        ports_addr,
    input  logic [DATA_W-1:0] ports_wrdata,
    output logic [DATA_W-1:0] ports_rddata,
    output logic [1:0]        rommap_win,
    output logic              rommap_ena,
    output logic              w5300_ports,
    output logic              w5300_rst_n,
    output logic              sl811_rst_n,
    input  logic              w5300_int_n,
    input  logic              sl811_intr,
    output logic              int_n
);

    localparam int unsigned      CNT_W    = $clog2(RST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_LEN);

    logic strb_s;
    logic wrena_s;
    logic strb_prev_q;
    logic wr_stb;
    logic wr_cfg;
    logic wr_rst;
    logic wr_int;

    zsync #(.RST_VAL(1'b1)) u_sync_strb (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (ports_wrstb_n),
        .q     (strb_s)
    );

    zsync #(.RST_VAL(1'b0)) u_sync_wrena (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (ports_wrena),
        .q     (wrena_s)
    );

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            strb_prev_q <= 1'b1;
        end else begin
            strb_prev_q <= strb_s;
        end
    end

    // Addr/data are held stable by the bus for the whole strobe-low window.
    assign wr_stb = ~strb_s & strb_prev_q & wrena_s;
    assign wr_cfg = wr_stb && (ports_addr == REG_CFG);
    assign wr_rst = wr_stb && (ports_addr == REG_RST);
    assign wr_int = wr_stb && (ports_addr == REG_INT);

    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (wr_cfg) begin
            cfg_d = ports_wrdata[CFG_W-1:0];
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else begin
            cfg_q <= cfg_d;
        end
    end

    assign rommap_win  = cfg_q[CFG_WIN_LSB +: 2];
    assign rommap_ena  = cfg_q[CFG_ENA_BIT];
    assign w5300_ports = cfg_q[CFG_W5P_BIT];

    logic [CNT_W-1:0] w5_cnt_q;
    logic [CNT_W-1:0] w5_cnt_d;
    logic [CNT_W-1:0] sl_cnt_q;
    logic [CNT_W-1:0] sl_cnt_d;
    logic             w5_active;
    logic             sl_active;

    // A write while a pulse is running reloads, stretching the pulse.
    always_comb begin
        w5_cnt_d = w5_cnt_q;
        sl_cnt_d = sl_cnt_q;
        if (wr_rst && ports_wrdata[RST_W5_BIT]) begin
            w5_cnt_d = CNT_LOAD;
        end else if (w5_cnt_q != '0) begin
            w5_cnt_d = w5_cnt_q - 1'b1;
        end
        if (wr_rst && ports_wrdata[RST_SL_BIT]) begin
            sl_cnt_d = CNT_LOAD;
        end else if (sl_cnt_q != '0) begin
            sl_cnt_d = sl_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            w5_cnt_q <= CNT_LOAD;
            sl_cnt_q <= CNT_LOAD;
        end else begin
            w5_cnt_q <= w5_cnt_d;
            sl_cnt_q <= sl_cnt_d;
        end
    end

    assign w5_active   = (w5_cnt_q != '0);
    assign sl_active   = (sl_cnt_q != '0);
    assign w5300_rst_n = ~w5_active;
    assign sl811_rst_n = ~sl_active;

    logic [DATA_W-1:0] int_rd;

`ifdef ZPORTS_INT_EN
    logic       w5_int_s;
    logic       sl_int_s;
    logic       w5_int_prev_q;
    logic       sl_int_prev_q;
    logic [1:0] int_set;
    logic [1:0] int_clr;
    logic [1:0] pend_q;
    logic [1:0] pend_d;
    logic [1:0] mask_q;
    logic [1:0] mask_d;
    logic       int_n_q;

    zsync #(.RST_VAL(1'b1)) u_sync_w5int (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (w5300_int_n),
        .q     (w5_int_s)
    );

    zsync #(.RST_VAL(1'b0)) u_sync_slint (
        .clk   (fclk),
        .rst_n (rst_n),
        .d     (sl811_intr),
        .q     (sl_int_s)
    );

    always_comb begin
        int_set             = '0;
        int_set[INT_SL_BIT] = sl_int_s & ~sl_int_prev_q;
        int_set[INT_W5_BIT] = ~w5_int_s & w5_int_prev_q;
        int_clr             = wr_int ? ports_wrdata[1:0] : 2'b00;
        mask_d              = wr_int ? ports_wrdata[INT_MASK_LSB +: 2] : mask_q;
        // A new edge beats a simultaneous clear so no event is lost.
        pend_d              = (pend_q & ~int_clr) | int_set;
    end

    // int_n is computed from next-state so a clear shows up one cycle after the write.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            w5_int_prev_q <= 1'b1;
            sl_int_prev_q <= 1'b0;
            pend_q        <= '0;
            mask_q        <= '0;
            int_n_q       <= 1'b1;
        end else begin
            w5_int_prev_q <= w5_int_s;
            sl_int_prev_q <= sl_int_s;
            pend_q        <= pend_d;
            mask_q        <= mask_d;
            int_n_q       <= ~|(pend_d & mask_d);
        end
    end

    assign int_rd = {2'b00, mask_q, 2'b00, pend_q};
    assign int_n  = int_n_q;

    logic unused_ok;
    assign unused_ok = ^{ports_wrdata[7:6]};
`else
    assign int_rd = '0;
    assign int_n  = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{ports_wrdata[7:4], w5300_int_n, sl811_intr, wr_int};
`endif

    always_comb begin
        ports_rddata = '0;
        case (ports_addr)
            REG_SLADDR: ports_rddata = SLADDR_RD_VAL;
            REG_CFG:    ports_rddata = {{(DATA_W-CFG_W){1'b0}}, cfg_q};
            REG_RST:    ports_rddata = {6'b0, sl_active, w5_active};
            REG_INT:    ports_rddata = int_rd;
            default:    ports_rddata = '0;
        endcase
    end

endmodule

// File: tb/tb_zports.sv
// Directed self-checking bench for zports; interrupt checks follow ZPORTS_INT_EN.
module tb_zports;

    logic       fclk;
    logic       rst_n;
    logic       ports_wrena;
    logic       ports_wrstb_n;
    logic [1:0] ports_addr;
    logic [7:0] ports_wrdata;
    logic [7:0] ports_rddata;
    logic [1:0] rommap_win;
    logic       rommap_ena;
    logic       w5300_ports;
    logic       w5300_rst_n;
    logic       sl811_rst_n;
    logic       w5300_int_n;
    logic       sl811_intr;
    logic       int_n;

    int n_vec = 0;
    int n_err = 0;

    zports #(.RST_LEN(32)) dut (
        .fclk          (fclk),
        .rst_n         (rst_n),
        .ports_wrena   (ports_wrena),
        .ports_wrstb_n (ports_wrstb_n),
        .ports_addr    (ports_addr),
        .ports_wrdata  (ports_wrdata),
        .ports_rddata  (ports_rddata),
        .rommap_win    (rommap_win),
        .rommap_ena    (rommap_ena),
        .w5300_ports   (w5300_ports),
        .w5300_rst_n   (w5300_rst_n),
        .sl811_rst_n   (sl811_rst_n),
        .w5300_int_n   (w5300_int_n),
        .sl811_intr    (sl811_intr),
        .int_n         (int_n)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] d);
        ports_addr = a;
        #1;
        d = ports_rddata;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic en);
        @(negedge fclk);
        ports_addr    = a;
        ports_wrdata  = d;
        ports_wrena   = en;
        ports_wrstb_n = 1'b0;
        repeat (4) @(posedge fclk);
        @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (3) @(negedge fclk);
        ports_wrena   = 1'b0;
    endtask

    // Counts edges after reset release until each chip reset deasserts.
    task automatic measure_reset_release(input string tag);
        int w5_hi;
        int sl_hi;
        w5_hi = -1;
        sl_hi = -1;
        @(negedge fclk);
        rst_n = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge fclk);
            #1;
            if (w5300_rst_n && w5_hi < 0) w5_hi = k;
            if (sl811_rst_n && sl_hi < 0) sl_hi = k;
            if (w5_hi >= 0 && sl_hi >= 0) break;
        end
        chk({tag, "_w5_len"}, w5_hi, 32);
        chk({tag, "_sl_len"}, sl_hi, 32);
    endtask

    initial begin
        logic [7:0] d;
        int lo;
        int hi;
        int sl_bad;
        int k_int;
        int int_hi_seen;

        rst_n         = 1'b0;
        ports_wrena   = 1'b0;
        ports_wrstb_n = 1'b1;
        ports_addr    = 2'd0;
        ports_wrdata  = 8'h00;
        w5300_int_n   = 1'b1;
        sl811_intr    = 1'b0;

        repeat (3) @(posedge fclk);
        #1;
        chk("rst_w5_low", w5300_rst_n, 0);
        chk("rst_sl_low", sl811_rst_n, 0);
        chk("rst_int_n", int_n, 1);
        rd(2'd1, d); chk("rst_cfg_rd", d, 8'h00);
        rd(2'd0, d); chk("rst_reg0_rd", d, 8'hFF);
        rd(2'd2, d); chk("rst_reg2_rd", d, 8'h03);

        measure_reset_release("release");
        rd(2'd1, d); chk("post_cfg_rd", d, 8'h00);
        chk("post_int_n", int_n, 1);

        // CFG write with latency check: still old after 2 edges, new after 3
        @(negedge fclk);
        ports_addr    = 2'd1;
        ports_wrdata  = 8'h0E;
        ports_wrena   = 1'b1;
        ports_wrstb_n = 1'b0;
        repeat (2) @(posedge fclk);
        #1;
        chk("cfg_lat2_ena", rommap_ena, 0);
        @(posedge fclk);
        #1;
        chk("cfg_lat3_ena", rommap_ena, 1);
        chk("cfg_win", rommap_win, 2'b10);
        chk("cfg_w5p", w5300_ports, 1);
        @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (3) @(negedge fclk);
        ports_wrena = 1'b0;
        rd(2'd1, d); chk("cfg_rd_0e", d, 8'h0E);

        do_write(2'd1, 8'h03, 1'b0);
        rd(2'd1, d); chk("cfg_wrena0", d, 8'h0E);

        do_write(2'd0, 8'h12, 1'b1);
        rd(2'd0, d); chk("reg0_ignored", d, 8'hFF);
        rd(2'd1, d); chk("reg0_no_cfg", d, 8'h0E);

        do_write(2'd1, 8'hF5, 1'b1);
        rd(2'd1, d); chk("cfg_rd_f5", d, 8'h05);
        chk("cfg_win_01", rommap_win, 2'b01);
        chk("cfg_w5p_0", w5300_ports, 0);

        // W5300 reset, re-triggered 10 cycles after the first strobe
        @(negedge fclk);
        ports_addr    = 2'd2;
        ports_wrdata  = 8'h01;
        ports_wrena   = 1'b1;
        ports_wrstb_n = 1'b0;
        lo = -1; hi = -1; sl_bad = 0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge fclk);
            #1;
            if (!w5300_rst_n && lo < 0) lo = k;
            if (w5300_rst_n && lo >= 0 && hi < 0) hi = k;
            if (!sl811_rst_n) sl_bad = 1;
            if (k == 20) chk("rst_rd_active", ports_rddata, 8'h01);
            @(negedge fclk);
            ports_wrstb_n = ((k >= 4 && k <= 9) || k >= 14) ? 1'b1 : 1'b0;
        end
        ports_wrena = 1'b0;
        chk("rst_w5_start", lo, 3);
        chk("rst_w5_len42", hi - lo, 42);
        chk("rst_sl_idle", sl_bad, 0);
        rd(2'd2, d); chk("rst_rd_idle", d, 8'h00);

        do_write(2'd2, 8'h02, 1'b1);
        rd(2'd2, d); chk("rst_rd_sl", d, 8'h02);
        chk("rst_sl_low", sl811_rst_n, 0);
        chk("rst_w5_high", w5300_rst_n, 1);
        repeat (40) @(negedge fclk);

        // Strobe held low 40 cycles must yield exactly one reload
        @(negedge fclk);
        ports_addr    = 2'd2;
        ports_wrdata  = 8'h01;
        ports_wrena   = 1'b1;
        ports_wrstb_n = 1'b0;
        lo = -1; hi = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge fclk);
            #1;
            if (!w5300_rst_n && lo < 0) lo = k;
            if (w5300_rst_n && lo >= 0 && hi < 0) hi = k;
        end
        @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (3) @(negedge fclk);
        ports_wrena = 1'b0;
        chk("long_strb_start", lo, 3);
        chk("long_strb_end", hi, 35);

`ifdef ZPORTS_INT_EN
        do_write(2'd3, 8'h30, 1'b1);
        rd(2'd3, d); chk("int_mask_rd", d, 8'h30);
        chk("int_n_idle", int_n, 1);
        @(negedge fclk);
        sl811_intr = 1'b1;
        k_int = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge fclk);
            #1;
            if (!int_n && k_int < 0) k_int = k;
        end
        @(negedge fclk);
        sl811_intr = 1'b0;
        chk("int_sl_fired", (k_int > 0 && k_int <= 4), 1);
        rd(2'd3, d); chk("int_sl_pend", d, 8'h31);

        do_write(2'd3, 8'h31, 1'b1);
        chk("int_clr_n", int_n, 1);
        rd(2'd3, d); chk("int_clr_rd", d, 8'h30);

        // W5300 edge and its W1C arrive through the synchronisers together
        @(negedge fclk);
        ports_addr    = 2'd3;
        ports_wrdata  = 8'h32;
        ports_wrena   = 1'b1;
        ports_wrstb_n = 1'b0;
        w5300_int_n   = 1'b0;
        repeat (4) @(posedge fclk);
        @(negedge fclk);
        ports_wrstb_n = 1'b1;
        repeat (3) @(negedge fclk);
        ports_wrena = 1'b0;
        w5300_int_n = 1'b1;
        repeat (4) @(negedge fclk);
        rd(2'd3, d); chk("int_set_wins", d, 8'h32);
        chk("int_w5_n", int_n, 0);
        do_write(2'd3, 8'h32, 1'b1);
        chk("int_w5_clr", int_n, 1);
`else
        do_write(2'd3, 8'h30, 1'b1);
        rd(2'd3, d); chk("noint_rd", d, 8'h00);
        @(negedge fclk);
        sl811_intr  = 1'b1;
        w5300_int_n = 1'b0;
        int_hi_seen = 1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge fclk);
            #1;
            if (!int_n) int_hi_seen = 0;
        end
        @(negedge fclk);
        sl811_intr  = 1'b0;
        w5300_int_n = 1'b1;
        chk("noint_int_n", int_hi_seen, 1);
        rd(2'd3, d); chk("noint_rd2", d, 8'h00);
`endif

        // Reset asserted mid-write: CFG must come back at its reset value
        @(negedge fclk);
        ports_addr    = 2'd1;
        ports_wrdata  = 8'h05;
        ports_wrena   = 1'b1;
        ports_wrstb_n = 1'b0;
        @(posedge fclk);
        #1;
        rst_n = 1'b0;
        #2;
        ports_wrstb_n = 1'b1;
        ports_wrena   = 1'b0;
        repeat (3) @(negedge fclk);
        rd(2'd1, d); chk("abort_cfg_rst", d, 8'h00);
        measure_reset_release("abort");
        rd(2'd1, d); chk("abort_cfg_rd", d, 8'h00);
        chk("abort_ena", rommap_ena, 0);
        chk("abort_int_n", int_n, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
